// File: rtl/vga_scan_ctrl_if.sv
// Sprite pixel-request bus between the raster controller (master) and every sprite source (slave).
// Each source returns its rgb/alpha one clock after it sees the requested address.
interface vga_scan_ctrl_if #(
  parameter int H_LEN = 10,
  parameter int V_LEN = 10,
  parameter int RGB_W = 12
);
  logic [H_LEN-1:0] req_x_addr_o;
  logic [V_LEN-1:0] req_y_addr_o;
  logic             v_sync_o;
  logic [RGB_W-1:0] me_rgb_i;
  logic             me_alpha_i;
  logic [RGB_W-1:0] bullet_rgb_i;
  logic             bullet_alpha_i;
  logic [RGB_W-1:0] enemy_rgb_i;
  logic             enemy_alpha_i;
  logic [RGB_W-1:0] bg_rgb_i;

  modport master (
    output req_x_addr_o, req_y_addr_o, v_sync_o,
    input  me_rgb_i, me_alpha_i, bullet_rgb_i, bullet_alpha_i,
           enemy_rgb_i, enemy_alpha_i, bg_rgb_i
  );

  modport slave (
    input  req_x_addr_o, req_y_addr_o, v_sync_o,
    output me_rgb_i, me_alpha_i, bullet_rgb_i, bullet_alpha_i,
           enemy_rgb_i, enemy_alpha_i, bg_rgb_i
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA raster generator and sprite compositor: requests pixels from the sprite sources,
// merges the returned layers by fixed priority and drives the registered VGA pins.
module vga_scan_ctrl #(
  parameter int H_DISP  = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int H_LEN   = 10,
  parameter int V_LEN   = 10,
  parameter int RGB_W   = 12
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic              en_i,
  vga_scan_ctrl_if.master   spr,
  output logic              vga_h_sync_o,
  output logic              vga_v_sync_o,
  output logic [RGB_W-1:0]  vga_rgb_o,
  output logic              frame_start_o
);

  localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;

  localparam logic [H_LEN-1:0] H_DISP_C   = H_LEN'(H_DISP);
  localparam logic [H_LEN-1:0] H_LAST_C   = H_LEN'(H_TOTAL - 1);
  localparam logic [H_LEN-1:0] HS_FIRST_C = H_LEN'(H_DISP + H_FRONT);
  localparam logic [H_LEN-1:0] HS_LAST_C  = H_LEN'(H_DISP + H_FRONT + H_SYNC - 1);
  localparam logic [V_LEN-1:0] V_DISP_C   = V_LEN'(V_DISP);
  localparam logic [V_LEN-1:0] V_LAST_C   = V_LEN'(V_TOTAL - 1);
  localparam logic [V_LEN-1:0] VS_FIRST_C = V_LEN'(V_DISP + V_FRONT);
  localparam logic [V_LEN-1:0] VS_LAST_C  = V_LEN'(V_DISP + V_FRONT + V_SYNC - 1);

  // Raster counters
  logic [H_LEN-1:0] h_cnt_q, h_cnt_d;
  logic [V_LEN-1:0] v_cnt_q, v_cnt_d;

  // Stage 1: timing of the pixel whose layer data is arriving this cycle
  logic active_d1_q, active_d1_d;
  logic h_sync_d1_q, h_sync_d1_d;
  logic v_sync_d1_q, v_sync_d1_d;

  // Stage 2: pin registers
  logic             vga_h_sync_q, vga_h_sync_d;
  logic             vga_v_sync_q, vga_v_sync_d;
  logic [RGB_W-1:0] vga_rgb_q, vga_rgb_d;
  logic             frame_start_q, frame_start_d;

  logic active;
  logic h_sync_raw;
  logic v_sync_raw;

  // NOTE: every signal written in an always_comb gets a default first, so no path
  // through the block leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST_C) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_comb begin
    active     = (h_cnt_q < H_DISP_C) && (v_cnt_q < V_DISP_C);
    h_sync_raw = !((h_cnt_q >= HS_FIRST_C) && (h_cnt_q <= HS_LAST_C));
    v_sync_raw = !((v_cnt_q >= VS_FIRST_C) && (v_cnt_q <= VS_LAST_C));
  end

  // Out-of-frame requests use all-ones so no sprite placed on screen can match.
  assign spr.req_x_addr_o = active ? h_cnt_q : '1;
  assign spr.req_y_addr_o = active ? v_cnt_q : '1;
  assign spr.v_sync_o     = v_sync_raw;

  always_comb begin
    active_d1_d   = active;
    h_sync_d1_d   = h_sync_raw;
    v_sync_d1_d   = v_sync_raw;
    vga_h_sync_d  = h_sync_d1_q;
    vga_v_sync_d  = v_sync_d1_q;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Layer priority: player craft, bullets, enemies, then background.
    vga_rgb_d = '0;
    if (active_d1_q) begin
      if (en_i && spr.me_alpha_i)          vga_rgb_d = spr.me_rgb_i;
      else if (en_i && spr.bullet_alpha_i) vga_rgb_d = spr.bullet_rgb_i;
      else if (en_i && spr.enemy_alpha_i)  vga_rgb_d = spr.enemy_rgb_i;
      else                                 vga_rgb_d = spr.bg_rgb_i;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      active_d1_q   <= 1'b0;
      h_sync_d1_q   <= 1'b1;
      v_sync_d1_q   <= 1'b1;
      vga_h_sync_q  <= 1'b1;
      vga_v_sync_q  <= 1'b1;
      vga_rgb_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      active_d1_q   <= active_d1_d;
      h_sync_d1_q   <= h_sync_d1_d;
      v_sync_d1_q   <= v_sync_d1_d;
      vga_h_sync_q  <= vga_h_sync_d;
      vga_v_sync_q  <= vga_v_sync_d;
      vga_rgb_q     <= vga_rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_h_sync_o  = vga_h_sync_q;
  assign vga_v_sync_o  = vga_v_sync_q;
  assign vga_rgb_o     = vga_rgb_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl: full horizontal timing with a shortened vertical
// frame (24+4+2+3 = 33 lines, 26400 clocks per frame).
module tb_vga_scan_ctrl;

  localparam int H_TOTAL = 800;
  localparam int V_DISP  = 24;
  localparam int FRAME   = 26400;

  logic        clk_vga = 1'b0;
  logic        rst_n   = 1'b0;
  logic        en_i    = 1'b1;
  logic        vga_h_sync_o;
  logic        vga_v_sync_o;
  logic [11:0] vga_rgb_o;
  logic        frame_start_o;

  vga_scan_ctrl_if #(.H_LEN(10), .V_LEN(10), .RGB_W(12)) spr ();

  vga_scan_ctrl #(
    .V_DISP (V_DISP),
    .V_FRONT(4),
    .V_SYNC (2),
    .V_BACK (3)
  ) dut (
    .clk_vga      (clk_vga),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .spr          (spr),
    .vga_h_sync_o (vga_h_sync_o),
    .vga_v_sync_o (vga_v_sync_o),
    .vga_rgb_o    (vga_rgb_o),
    .frame_start_o(frame_start_o)
  );

  always #5 clk_vga = ~clk_vga;

  int checks    = 0;
  int errors    = 0;
  int k         = 0;   // clock edges since the last reset release
  int fs_pulses = 0;
  int fs_last_k = 0;
  int fs_gap    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_vga);
    @(negedge clk_vga);
    k++;
    if (frame_start_o === 1'b1) begin
      fs_pulses++;
      fs_gap    = k - fs_last_k;
      fs_last_k = k;
    end
  endtask

  task automatic goto(input int target);
    while (k < target) tick();
  endtask

  task automatic set_layers(input logic me_a, input logic [11:0] me_c,
                            input logic bu_a, input logic [11:0] bu_c,
                            input logic en_a, input logic [11:0] en_c,
                            input logic [11:0] bg_c);
    spr.me_alpha_i     = me_a;
    spr.me_rgb_i       = me_c;
    spr.bullet_alpha_i = bu_a;
    spr.bullet_rgb_i   = bu_c;
    spr.enemy_alpha_i  = en_a;
    spr.enemy_rgb_i    = en_c;
    spr.bg_rgb_i       = bg_c;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int h, v, exp_xy;
    int hs_low, hs_first, x_blank, x_bad;
    int vs_low, vs_first, vvs_low, vvs_first, y_bad;

    set_layers(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000);
    repeat (2) @(negedge clk_vga);

    check("rst_vga_h_sync", 32'(vga_h_sync_o), 32'd1);
    check("rst_vga_v_sync", 32'(vga_v_sync_o), 32'd1);
    check("rst_rgb", 32'(vga_rgb_o), 32'h0);
    check("rst_frame_start", 32'(frame_start_o), 32'd0);
    check("rst_v_sync_o", 32'(spr.v_sync_o), 32'd1);

    rst_n = 1'b1;
    k = 0;
    check("rel_req_x", 32'(spr.req_x_addr_o), 32'd0);
    check("rel_req_y", 32'(spr.req_y_addr_o), 32'd0);
    tick();
    check("rel_frame_start_hi", 32'(frame_start_o), 32'd1);
    check("rel_req_x_1", 32'(spr.req_x_addr_o), 32'd1);
    tick();
    check("rel_frame_start_lo", 32'(frame_start_o), 32'd0);

    // One full line: raw hsync 656..751 reaches the pin two clocks later.
    hs_low = 0; hs_first = -1; x_blank = 0; x_bad = 0;
    for (int i = 0; i < H_TOTAL; i++) begin
      h = k % H_TOTAL;
      v = k / H_TOTAL;
      exp_xy = (h < 640 && v < V_DISP) ? h : 1023;
      if (32'(spr.req_x_addr_o) != exp_xy) x_bad++;
      if (spr.req_x_addr_o == 10'd1023) x_blank++;
      if (vga_h_sync_o === 1'b0) begin
        if (hs_first < 0) hs_first = h;
        hs_low++;
      end
      tick();
    end
    check("line_hsync_first", 32'(hs_first), 32'd658);
    check("line_hsync_width", 32'(hs_low), 32'd96);
    check("line_req_x_blank", 32'(x_blank), 32'd160);
    check("line_req_x_bad", 32'(x_bad), 32'd0);

    // Priority at pixel (100,10).
    goto(10 * H_TOTAL + 100);
    check("prio_req_x", 32'(spr.req_x_addr_o), 32'd100);
    check("prio_req_y", 32'(spr.req_y_addr_o), 32'd10);
    set_layers(1'b1, 12'hFFF, 1'b0, 12'h000, 1'b1, 12'h0F0, 12'h00F);
    tick(); tick();
    check("prio_me", 32'(vga_rgb_o), 32'hFFF);
    spr.me_alpha_i = 1'b0;
    tick();
    check("prio_enemy", 32'(vga_rgb_o), 32'h0F0);
    en_i = 1'b0;
    tick();
    check("prio_en_off", 32'(vga_rgb_o), 32'h00F);
    en_i = 1'b1;
    spr.bullet_alpha_i = 1'b1;
    spr.bullet_rgb_i   = 12'hF00;
    tick();
    check("prio_bullet", 32'(vga_rgb_o), 32'hF00);

    // Blanking on line 11: last active pixel, first blank pixel, and h=700.
    goto(11 * H_TOTAL + 639);
    set_layers(1'b1, 12'hFFF, 1'b1, 12'hF00, 1'b1, 12'h0F0, 12'h00F);
    tick(); tick();
    check("blank_px639", 32'(vga_rgb_o), 32'hFFF);
    tick();
    check("blank_px640", 32'(vga_rgb_o), 32'h0);
    goto(11 * H_TOTAL + 700);
    tick(); tick();
    check("blank_px700", 32'(vga_rgb_o), 32'h0);

    // Asynchronous reset at (300,15).
    set_layers(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 12'h00F);
    goto(15 * H_TOTAL + 300);
    check("pre_rst_rgb", 32'(vga_rgb_o), 32'h00F);
    check("pre_rst_req_x", 32'(spr.req_x_addr_o), 32'd300);
    rst_n = 1'b0;
    #1;
    check("async_req_x", 32'(spr.req_x_addr_o), 32'd0);
    check("async_req_y", 32'(spr.req_y_addr_o), 32'd0);
    check("async_rgb", 32'(vga_rgb_o), 32'h0);
    check("async_vga_h_sync", 32'(vga_h_sync_o), 32'd1);
    check("async_vga_v_sync", 32'(vga_v_sync_o), 32'd1);
    repeat (3) @(posedge clk_vga);
    @(negedge clk_vga);
    check("held_req_x", 32'(spr.req_x_addr_o), 32'd0);
    check("held_frame_start", 32'(frame_start_o), 32'd0);
    rst_n = 1'b1;
    k = 0; fs_pulses = 0; fs_last_k = 0; fs_gap = 0;
    tick();
    check("restart_frame_start", 32'(frame_start_o), 32'd1);
    check("restart_req_x", 32'(spr.req_x_addr_o), 32'd1);
    check("restart_req_y", 32'(spr.req_y_addr_o), 32'd0);

    // Rest of the frame: vsync window on lines 28..29 and vertical blanking addresses.
    vs_low = 0; vs_first = -1; vvs_low = 0; vvs_first = -1; y_bad = 0;
    while (k < FRAME - 1) begin
      h = k % H_TOTAL;
      v = k / H_TOTAL;
      exp_xy = (h < 640 && v < V_DISP) ? v : 1023;
      if (32'(spr.req_y_addr_o) != exp_xy) y_bad++;
      if (spr.v_sync_o === 1'b0) begin
        if (vs_first < 0) vs_first = k;
        vs_low++;
      end
      if (vga_v_sync_o === 1'b0) begin
        if (vvs_first < 0) vvs_first = k;
        vvs_low++;
      end
      tick();
    end
    check("frame_vsync_first", 32'(vs_first), 32'd22400);
    check("frame_vsync_width", 32'(vs_low), 32'd1600);
    check("frame_vga_vsync_first", 32'(vvs_first), 32'd22402);
    check("frame_vga_vsync_width", 32'(vvs_low), 32'd1600);
    check("frame_req_y_bad", 32'(y_bad), 32'd0);

    // Simultaneous h/v wrap and the next frame_start pulse.
    check("wrap_last_req_x", 32'(spr.req_x_addr_o), 32'd1023);
    check("wrap_last_req_y", 32'(spr.req_y_addr_o), 32'd1023);
    tick();
    check("wrap_req_x", 32'(spr.req_x_addr_o), 32'd0);
    check("wrap_req_y", 32'(spr.req_y_addr_o), 32'd0);
    check("wrap_frame_start_lo", 32'(frame_start_o), 32'd0);
    check("wrap_pulses_before", 32'(fs_pulses), 32'd1);
    tick();
    check("next_frame_start", 32'(frame_start_o), 32'd1);
    check("frame_period", 32'(fs_gap), 32'd26400);
    check("frame_pulses", 32'(fs_pulses), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
